// File: rtl/s_mem_pkg.sv
// Shared definitions for the S-memory read-back checker.
// Provides default memory geometry and the checker's state type.
package s_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// Read-latency alignment pipe for the S-memory checker.
// Carries {valid, addr} for each issued read so that it arrives at the
// compare stage in the same cycle as the memory's q for that address.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 drop every in-flight entry (and the incoming one)
//   in_valid, in_addr     entry issued this cycle
//   out_valid, out_addr   entry whose read data is on q this cycle
module rd_latency_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else begin
            valid[0] <= in_valid & ~flush;
            addr[0]  <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1] & ~flush;
                addr[i]  <= addr[i-1];
            end
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_addr  = addr[DEPTH-1];

endmodule

// File: rtl/s_memory_checker.sv
// Read-back checker for the S-memory: after the populate phase it scans
// every address and verifies the identity pattern s[i] == i.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start            rising edge launches a scan (ignored while busy)
//   address, wren    memory read address (registered), write enable (always 0)
//   q                memory read data, READ_LATENCY edges behind address
//   busy, finish     scan in progress, one-cycle end-of-scan pulse
//   pass, fail       scan result, held until the next launch
//   mismatch_addr    address of the first mismatch
//   mismatch_data    q value seen at the first mismatch
//   error_count      mismatch count, saturating at 2**ADDR_W
module s_memory_checker
    import s_mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int READ_LATENCY  = 1,
    parameter int STOP_ON_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    input  logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              finish,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] mismatch_addr,
    output logic [DATA_W-1:0] mismatch_data,
    output logic [ADDR_W:0]   error_count
);

    localparam logic [ADDR_W:0] ERR_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t            state;
    logic              start_q;
    logic [1:0]        drain_cnt;
    logic              launch;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;
    logic              stop;

    assign launch   = start & ~start_q & (state == IDLE);
    assign exp_word = DATA_W'(cmp_addr);
    assign mismatch = cmp_valid && (q != exp_word);
    assign stop     = (STOP_ON_FIRST != 0) && mismatch;
    assign wren     = 1'b0;
    assign finish   = (state == DONE);

    // One entry per address shown in READ; a stop flushes the in-flight reads
    // so nothing past the first mismatch is ever compared.
    rd_latency_pipe #(
        .DEPTH  (READ_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (stop),
        .in_valid  (state == READ),
        .in_addr   (address),
        .out_valid (cmp_valid),
        .out_addr  (cmp_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            drain_cnt     <= '0;
            address       <= '0;
            busy          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            mismatch_addr <= '0;
            mismatch_data <= '0;
            error_count   <= '0;
        end else begin
            start_q <= start;

            if (mismatch) begin
                if (error_count != ERR_MAX) begin
                    error_count <= error_count + 1'b1;
                end
                if (!fail) begin
                    fail          <= 1'b1;
                    mismatch_addr <= cmp_addr;
                    mismatch_data <= q;
                end
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        mismatch_addr <= '0;
                        mismatch_data <= '0;
                        error_count   <= '0;
                        address       <= '0;
                        busy          <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    // Address is frozen on a stop so it never runs further
                    // than READ_LATENCY past the failing location.
                    if (stop) begin
                        state <= DONE;
                    end else if (address == '1) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        address <= address + 1'b1;
                    end
                end
                DRAIN: begin
                    if (stop || drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    pass  <= ~fail;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s_memory_checker.sv
// Self-checking bench for s_memory_checker. Three instances run side by side
// on shared clock/reset/start, each with its own memory image:
//   0: READ_LATENCY=1, full scan   1: READ_LATENCY=2, full scan
//   2: READ_LATENCY=2, STOP_ON_FIRST=1
// Expected results come from a plain scan of each memory image.
module tb_s_memory_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;

    logic [7:0] mem [3][256];

    logic [7:0] addr_s [3];
    logic       wren_s [3];
    logic       busy_s [3];
    logic       fin_s  [3];
    logic       pass_s [3];
    logic       fail_s [3];
    logic [7:0] mma_s  [3];
    logic [7:0] mmd_s  [3];
    logic [8:0] err_s  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic int dlat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit dstop(input int d);
        return d == 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] q1;
        logic [7:0] q2;
        logic [7:0] qd;

        // Synchronous-read memory model, one or two register stages deep.
        always @(posedge clk) begin
            q1 <= mem[g][addr_s[g]];
            q2 <= q1;
        end
        assign qd = (g == 0) ? q1 : q2;

        s_memory_checker #(
            .ADDR_W        (8),
            .DATA_W        (8),
            .READ_LATENCY  ((g == 0) ? 1 : 2),
            .STOP_ON_FIRST ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (start),
            .address       (addr_s[g]),
            .wren          (wren_s[g]),
            .q             (qd),
            .busy          (busy_s[g]),
            .finish        (fin_s[g]),
            .pass          (pass_s[g]),
            .fail          (fail_s[g]),
            .mismatch_addr (mma_s[g]),
            .mismatch_data (mmd_s[g]),
            .error_count   (err_s[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_identity();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++)
                mem[d][i] = 8'(i);
    endtask

    task automatic corrupt(input int a, input logic [7:0] v);
        for (int d = 0; d < 3; d++) mem[d][a] = v;
    endtask

    // Reference: walk the image in address order collecting mismatches;
    // a stop-on-first checker sees only the first one.
    function automatic void ref_model(input int d, output bit any, output int first,
                                      output int cnt);
        any = 0;
        first = 0;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[d][i] != 8'(i)) begin
                if (!any) begin
                    any = 1;
                    first = i;
                end
                cnt++;
                if (dstop(d)) break;
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_ctl%0d", tag, d),
                  {28'd0, busy_s[d], fin_s[d], pass_s[d], fail_s[d]}, 32'd0);
            check($sformatf("%s_addr%0d", tag, d), {24'd0, addr_s[d]}, 32'd0);
            check($sformatf("%s_mm%0d", tag, d), {16'd0, mma_s[d], mmd_s[d]}, 32'd0);
            check($sformatf("%s_err%0d", tag, d), {23'd0, err_s[d]}, 32'd0);
            check($sformatf("%s_wren%0d", tag, d), {31'd0, wren_s[d]}, 32'd0);
        end
    endtask

    // n counts edges after the launch edge: at the negedge tagged n the DUT
    // has seen edge launch+n. Address a is shown at n == a, and the final
    // finish pulse is expected at n == 256 + READ_LATENCY (full scan) or
    // a + 1 + READ_LATENCY (stop at first mismatch a).
    task automatic run_scan(input string tag, input bit toggle_start);
        bit any [3];
        int first [3];
        int cnt [3];
        int exp_fin [3];
        int fin_n [3];
        int fin_cnt [3];
        int bad_addr [3];
        int bad_busy [3];
        int bad_wren;
        bad_wren = 0;
        for (int d = 0; d < 3; d++) begin
            ref_model(d, any[d], first[d], cnt[d]);
            exp_fin[d] = (dstop(d) && any[d]) ? first[d] + 1 + dlat(d) : 256 + dlat(d);
            fin_n[d] = -1;
            fin_cnt[d] = 0;
            bad_addr[d] = 0;
            bad_busy[d] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!toggle_start && n == 0) start = 1'b0;
            if (toggle_start && (n == 40 || n == 90 || n == 200)) start = 1'b0;
            if (toggle_start && (n == 41 || n == 91 || n == 201)) start = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (fin_s[d]) begin
                    fin_cnt[d]++;
                    if (fin_cnt[d] == 1) fin_n[d] = n;
                end
                if (wren_s[d]) bad_wren++;
                if (n < exp_fin[d] && !busy_s[d]) bad_busy[d]++;
                if (n > exp_fin[d] && busy_s[d]) bad_busy[d]++;
                if (n <= exp_fin[d]) begin
                    if (dstop(d) && any[d]) begin
                        if (n <= first[d] && int'(addr_s[d]) != n) bad_addr[d]++;
                        if (int'(addr_s[d]) > first[d] + dlat(d)) bad_addr[d]++;
                    end else begin
                        if (int'(addr_s[d]) != ((n > 255) ? 255 : n)) bad_addr[d]++;
                    end
                end
            end
        end
        start = 1'b0;
        check({tag, "_wren"}, bad_wren, 0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_fin_count%0d", tag, d), fin_cnt[d], 1);
            check($sformatf("%s_fin_time%0d", tag, d), fin_n[d], exp_fin[d]);
            check($sformatf("%s_addr_seq%0d", tag, d), bad_addr[d], 0);
            check($sformatf("%s_busy%0d", tag, d), bad_busy[d], 0);
            check($sformatf("%s_pass%0d", tag, d), {31'd0, pass_s[d]}, {31'd0, !any[d]});
            check($sformatf("%s_fail%0d", tag, d), {31'd0, fail_s[d]}, {31'd0, any[d]});
            check($sformatf("%s_mm_addr%0d", tag, d), {24'd0, mma_s[d]}, any[d] ? first[d] : 0);
            check($sformatf("%s_mm_data%0d", tag, d), {24'd0, mmd_s[d]},
                  any[d] ? {24'd0, mem[d][first[d]]} : 32'd0);
            check($sformatf("%s_err_count%0d", tag, d), {23'd0, err_s[d]}, cnt[d]);
        end
    endtask

    initial begin
        int fin_seen;
        fill_identity();
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run_scan("identity", 0);

        fill_identity();
        corrupt(8'h5A, 8'hFF);
        run_scan("single_5a", 0);

        fill_identity();
        corrupt(8'h03, 8'h00);
        corrupt(8'hF0, 8'h00);
        run_scan("pair_03_f0", 0);

        fill_identity();
        corrupt(8'h10, 8'h77);
        run_scan("stop_10", 0);

        fill_identity();
        corrupt(8'hFF, 8'h00);
        run_scan("last_addr", 0);

        for (int i = 0; i < 256; i++) corrupt(i, ~8'(i));
        run_scan("all_bad", 0);

        for (int r = 0; r < 5; r++) begin
            fill_identity();
            for (int k = 0; k < r; k++) begin
                int a;
                logic [7:0] v;
                a = $urandom_range(0, 255);
                v = 8'($urandom_range(0, 255));
                if (v == 8'(a)) v = v ^ 8'h01;
                corrupt(a, v);
            end
            run_scan($sformatf("rand%0d", r), 0);
        end

        fill_identity();
        run_scan("start_held", 1);

        // Abort mid-scan with a mismatch already latched, then rescan clean.
        fill_identity();
        corrupt(8'h05, 8'hAA);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 128; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
        end
        check("pre_rst_addr", {24'd0, addr_s[0]}, 32'h80);
        check("pre_rst_fail", {31'd0, fail_s[0]}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        fin_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (fin_s[d]) fin_seen++;
        end
        check("mid_rst_no_finish", fin_seen, 0);
        reset_n = 1'b1;
        fill_identity();
        run_scan("post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s_memory_checker.md
Name: s_memory_checker

Overview:
- Read-back engine for the 256-entry S-memory: scans every address after the populate phase and checks the identity pattern s[i] == i.
- Reports pass/fail, the first mismatching address/data and a mismatch count.
- Sits beside the populate counter on the same memory port.
  - Drives address and a constant-0 write enable.
  - Top level muxes memory address/wren between the two blocks on the counter's finish.

Parameters:
- ADDR_W, 8: memory address width; depth = 2**ADDR_W.
- DATA_W, 8: memory data width; expected word = address[DATA_W-1:0] (zero-extended if DATA_W > ADDR_W).
- READ_LATENCY, 1: clock edges from address sampled by the memory to q valid; legal values 1 or 2.
- STOP_ON_FIRST, 0: 1 = abort the scan at the first mismatch.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; rising edge launches a scan.
- address  out  ADDR_W  memory read address, registered.
- wren  out  1  memory write enable; constant 0.
- q  in  DATA_W  memory read data.
- busy  out  1  high from launch until finish.
- finish  out  1  one-cycle pulse at end of scan.
- pass  out  1  scan completed with zero mismatches; held until next launch.
- fail  out  1  at least one mismatch; held until next launch.
- mismatch_addr  out  ADDR_W  address of first mismatch.
- mismatch_data  out  DATA_W  q value at first mismatch.
- error_count  out  ADDR_W+1  number of mismatches, saturates at 2**ADDR_W.

Behaviour:
- Reset, asynchronous on reset_n low:
  - State IDLE; all outputs 0, including address, busy, finish, pass, fail, mismatch_*, error_count.
  - start edge register cleared.
  - Reset mid-scan aborts immediately; no finish pulse.
- start edge detect: start_q registered; launch when start & ~start_q in IDLE. Edges while busy are ignored.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE, on launch:
  - Clear pass, fail, mismatch_*, error_count.
  - address <= 0, busy <= 1, go to READ.
- READ: address increments by 1 each cycle. On the cycle address == 2**ADDR_W-1, go to DRAIN; address holds (no wrap).
- Compare pipeline:
  - READ_LATENCY-deep shift register carries {valid, addr}.
  - Entry issued with address a is compared against q READ_LATENCY cycles after address first shows a.
  - Exactly one compare per address; no compares in IDLE/DONE.
- On a mismatch:
  - error_count += 1, saturating.
  - If it is the first mismatch: latch mismatch_addr/mismatch_data and set fail.
  - STOP_ON_FIRST=1: flush the pipeline valids and jump to DONE next cycle.
- DRAIN: stay READ_LATENCY cycles so the last compares complete, then go to DONE.
- DONE, one cycle:
  - finish = 1, busy <= 0.
  - pass <= ~fail.
  - Return to IDLE.
- Full-scan latency: launch edge k, finish high in the cycle after edge k + 2**ADDR_W + READ_LATENCY.
- Simultaneous launch edge and reset: reset wins.
- A start still held high after DONE does not relaunch; a new rising edge is required.

Decomposition:
- Package s_mem_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum (IDLE, READ, DRAIN, DONE).
  - MEM_DEPTH constant.
- One sub-module: rd_latency_pipe (parameterised valid/addr shift register, depth READ_LATENCY, async active-low reset).

Test Plan:
- Memory model preloaded s[i]=i, READ_LATENCY=1, pulse start -> finish exactly once, 258 cycles after launch edge; pass=1, fail=0, error_count=0, addresses 0..255 each issued once.
- Preload s[0x5A]=0xFF, else identity -> fail=1, pass=0, mismatch_addr=0x5A, mismatch_data=0xFF, error_count=1.
- Corrupt 0x03 and 0xF0 (=0x00), READ_LATENCY=2 -> mismatch_addr=0x03, error_count=2, finish 259 cycles after launch.
- STOP_ON_FIRST=1, corrupt 0x10 -> finish within READ_LATENCY+2 cycles of address 0x10 being issued; address never exceeds 0x10+READ_LATENCY; error_count=1.
- reset_n low at address 0x80 -> all outputs 0 same cycle, no finish; new start edge after release rescans from 0 and passes.
- start held high across finish, plus extra start pulses mid-scan -> exactly one scan and one finish; wren stays 0 throughout.
